// File: rtl/mul_sequencer_if.sv
// Handshake bundle between MiniAlu decode/RAM write port and the multi-cycle multiplier.
// The master drives start and operands; the slave (sequencer) returns stall/busy and the RAM write.
interface mul_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]  multiplier;
  logic [ADDR_W-1:0] destination;
  logic              busy;
  logic              stall;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [WIDTH-1:0]  result;
  logic              done;

  modport master (
    output start, multiplicand, multiplier, destination,
    input  busy, stall, write_enable, write_address, result, done
  );

  modport slave (
    input  start, multiplicand, multiplier, destination,
    output busy, stall, write_enable, write_address, result, done
  );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-4 shift-add multiplier controller: IDLE -> RUN (2 bits/step) -> WRITE (one RAM write).
// Optional macro MUL_EARLY_EXIT_EN ends RUN as soon as no multiplier bits remain.
module mul_sequencer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  mul_sequencer_if.slave bus
);
  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [2*WIDTH-1:0]  a_reg;
  logic [2*WIDTH-1:0]  acc_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [ADDR_W-1:0]   dest_reg;
  logic [2*WIDTH-1:0]  pp;
  logic                last_step;

  always_comb begin
    pp = '0;
    case (b_reg[1:0])
      2'd0: pp = '0;
      2'd1: pp = a_reg;
      2'd2: pp = a_reg << 1;
      2'd3: pp = a_reg + (a_reg << 1);
      default: pp = '0;
    endcase
  end

`ifdef MUL_EARLY_EXIT_EN
  // Stop once the shifted-out multiplier has no set bits left.
  assign last_step = (count_reg == CNT_W'(HALF - 1)) || (b_reg[WIDTH-1:2] == '0);
`else
  assign last_step = (count_reg == CNT_W'(HALF - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      dest_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= {{WIDTH{1'b0}}, bus.multiplicand};
            b_reg     <= bus.multiplier;
            dest_reg  <= bus.destination;
            acc_reg   <= '0;
            count_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_reg + pp;
          a_reg     <= a_reg << 2;
          b_reg     <= b_reg >> 2;
          count_reg <= count_reg + 1'b1;
          if (last_step) state_reg <= WRITE;
        end
        WRITE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; only stall looks at start, so decode can be held the same cycle.
  assign bus.busy          = (state_reg == RUN) || (state_reg == WRITE);
  assign bus.stall         = ((state_reg == IDLE) && bus.start) || (state_reg == RUN);
  assign bus.write_enable  = (state_reg == WRITE);
  assign bus.done          = (state_reg == WRITE);
  assign bus.result        = (state_reg == WRITE) ? acc_reg[WIDTH-1:0] : '0;
  assign bus.write_address = dest_reg;
endmodule
